extractor_stream_arbiter: RTL and testbench

- Packet-atomic round-robin arbiter that shares one message_extractor input among NUM_PORTS Avalon-ST 64-bit sources.
- Sits directly upstream of message_extractor; its m_* outputs connect to the extractor's in_* ports, and m_ready comes from the extractor's in_ready.
- Grant is held from startofpacket through endofpacket, so beats from different packets never interleave.

---
 rtl/extractor_stream_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_extractor_stream_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/extractor_stream_arbiter.sv
// Packet-atomic round-robin arbiter feeding a single message_extractor input.
// Optional macro ARB_TIMEOUT_EN adds an idle-beat timeout with packet abort and per-port flush.
module extractor_stream_arbiter #(
    parameter int NUM_PORTS      = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_PORTS-1:0]    src_valid,
    input  logic [NUM_PORTS-1:0]    src_startofpacket,
    input  logic [NUM_PORTS-1:0]    src_endofpacket,
    input  logic [NUM_PORTS-1:0]    src_error,
    input  logic [3*NUM_PORTS-1:0]  src_empty,
    input  logic [64*NUM_PORTS-1:0] src_data,
    output logic [NUM_PORTS-1:0]    src_ready,
    output logic                    m_valid,
    output logic                    m_startofpacket,
    output logic                    m_endofpacket,
    output logic                    m_error,
    output logic [2:0]              m_empty,
    output logic [63:0]             m_data,
    input  logic                    m_ready,
    output logic [NUM_PORTS-1:0]    grant,
    output logic                    busy,
    output logic                    drop_pulse,
    output logic                    timeout_pulse
);

    localparam int IDX_W = $clog2(NUM_PORTS);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
`ifdef ARB_TIMEOUT_EN
    localparam logic [1:0] S_ABORT = 2'd2;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
`endif

    if (NUM_PORTS < 2 || NUM_PORTS > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("extractor_stream_arbiter: parameter out of range");
    end

    logic [1:0]           r_state;
    logic [NUM_PORTS-1:0] r_grant;
    logic [IDX_W-1:0]     r_gidx;
    logic [IDX_W-1:0]     r_last;

    logic [63:0]          w_data  [NUM_PORTS];
    logic [2:0]           w_empty [NUM_PORTS];
    logic                 w_sel_valid;
    logic                 w_sel_eop;
    logic                 w_xfer;
    logic [NUM_PORTS-1:0] w_cand;
    logic [NUM_PORTS-1:0] w_drop;
    logic [NUM_PORTS-1:0] w_flush_drop;
    logic [IDX_W:0]       w_try;
    logic [IDX_W-1:0]     w_win;
    logic                 w_win_found;
    logic                 w_timeout;

    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
        assign w_data[gi]  = src_data[64*gi +: 64];
        assign w_empty[gi] = src_empty[3*gi +: 3];
    end

    assign w_sel_valid = src_valid[r_gidx];
    assign w_sel_eop   = src_endofpacket[r_gidx];
    assign w_xfer      = (r_state == S_BUSY) && w_sel_valid && m_ready;
    assign w_cand      = src_valid & src_startofpacket;

    // Rotating search starting one past the last granted port.
    always_comb begin
        w_try       = '0;
        w_win       = '0;
        w_win_found = 1'b0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            w_try = {1'b0, r_last} + (IDX_W+1)'(k);
            if (w_try >= (IDX_W+1)'(NUM_PORTS)) begin
                w_try = w_try - (IDX_W+1)'(NUM_PORTS);
            end
            if (!w_win_found && w_cand[w_try[IDX_W-1:0]]) begin
                w_win       = w_try[IDX_W-1:0];
                w_win_found = 1'b1;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic [CNT_W-1:0]     r_cnt;
    logic [NUM_PORTS-1:0] r_flush;

    assign w_flush_drop = r_flush & src_valid & ~src_startofpacket & ~r_grant;
    assign w_timeout    = !reset && (r_state == S_BUSY) && !w_sel_valid &&
                          (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_flush_drop = '0;
    assign w_timeout    = 1'b0;
`endif

    always_comb begin
        m_valid         = 1'b0;
        m_startofpacket = 1'b0;
        m_endofpacket   = 1'b0;
        m_error         = 1'b0;
        m_empty         = '0;
        m_data          = '0;
        src_ready       = '0;
        w_drop          = '0;
        if (!reset) begin
            case (r_state)
                S_IDLE: begin
                    w_drop = src_valid & ~src_startofpacket;
                end
                S_BUSY: begin
                    m_valid         = w_sel_valid;
                    m_startofpacket = src_startofpacket[r_gidx];
                    m_endofpacket   = w_sel_eop;
                    m_error         = src_error[r_gidx];
                    m_empty         = w_empty[r_gidx];
                    m_data          = w_data[r_gidx];
                    src_ready       = r_grant & {NUM_PORTS{m_ready}};
                    w_drop          = w_flush_drop;
                end
`ifdef ARB_TIMEOUT_EN
                S_ABORT: begin
                    m_valid       = 1'b1;
                    m_endofpacket = 1'b1;
                    m_error       = 1'b1;
                    m_empty       = 3'd7;
                    w_drop        = w_flush_drop;
                end
`endif
                default: ;
            endcase
            src_ready = src_ready | w_drop;
        end
    end

    assign drop_pulse    = |w_drop;
    assign timeout_pulse = w_timeout;
    assign grant         = reset ? '0 : r_grant;
    assign busy          = !reset && (r_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_gidx  <= '0;
            r_last  <= IDX_W'(NUM_PORTS - 1);
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_win_found) begin
                        r_grant <= NUM_PORTS'(1) << w_win;
                        r_gidx  <= w_win;
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (w_xfer && w_sel_eop) begin
                        r_last  <= r_gidx;
                        r_grant <= '0;
                        r_state <= S_IDLE;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (w_timeout) begin
                        r_state <= S_ABORT;
                    end
`endif
                end
`ifdef ARB_TIMEOUT_EN
                S_ABORT: begin
                    if (m_ready) begin
                        r_last  <= r_gidx;
                        r_grant <= '0;
                        r_state <= S_IDLE;
                    end
                end
`endif
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef ARB_TIMEOUT_EN
    // Counter restarts outside BUSY, so every grant begins with a fresh budget.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= '0;
            r_flush <= '0;
        end else begin
            if (r_state != S_BUSY || w_xfer || w_timeout) begin
                r_cnt <= '0;
            end else if (!w_sel_valid) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (src_valid[i] && src_startofpacket[i]) begin
                    r_flush[i] <= 1'b0;
                end else if (w_drop[i] && src_endofpacket[i]) begin
                    r_flush[i] <= 1'b0;
                end
            end
            if (r_state == S_ABORT && m_ready) begin
                r_flush[r_gidx] <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_extractor_stream_arbiter.sv
// Directed table-driven bench for extractor_stream_arbiter (4 ports, timeout of 8 when ARB_TIMEOUT_EN is set).
module tb_extractor_stream_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   src_valid, src_startofpacket, src_endofpacket, src_error, src_ready;
  logic [11:0]  src_empty;
  logic [255:0] src_data;
  logic         m_valid, m_startofpacket, m_endofpacket, m_error, m_ready;
  logic [2:0]   m_empty;
  logic [63:0]  m_data;
  logic [3:0]   grant;
  logic         busy, drop_pulse, timeout_pulse;

  int checks = 0;
  int failures = 0;
  int cur = 0;

  extractor_stream_arbiter #(.NUM_PORTS(4), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset),
    .src_valid(src_valid), .src_startofpacket(src_startofpacket),
    .src_endofpacket(src_endofpacket), .src_error(src_error),
    .src_empty(src_empty), .src_data(src_data), .src_ready(src_ready),
    .m_valid(m_valid), .m_startofpacket(m_startofpacket),
    .m_endofpacket(m_endofpacket), .m_error(m_error),
    .m_empty(m_empty), .m_data(m_data), .m_ready(m_ready),
    .grant(grant), .busy(busy), .drop_pulse(drop_pulse), .timeout_pulse(timeout_pulse)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic        rst, rdy;
    logic [3:0]  vld, sop, eop;
    logic        err;
    logic [2:0]  emp;
    logic [15:0] tag;
    logic [3:0]  x_grant;
    logic        x_busy, x_mv, x_msop, x_meop, x_merr;
    logic [2:0]  x_memp;
    logic [63:0] x_mdata;
    logic [3:0]  x_rdy;
    logic        x_drop;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [63:0] dat(input int p, input logic [15:0] t);
    return {8'(p), 40'h0, t};
  endfunction

  function automatic vec_t mk(input logic rst, rdy, input logic [3:0] vld, sop, eop,
                              input logic err, input logic [2:0] emp, input logic [15:0] tag,
                              input logic [3:0] xg, input logic xb, xv, xs, xe, xr,
                              input logic [2:0] xm, input logic [63:0] xd,
                              input logic [3:0] xrdy, input logic xdrop);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.vld = vld; v.sop = sop; v.eop = eop; v.err = err;
    v.emp = emp; v.tag = tag; v.x_grant = xg; v.x_busy = xb; v.x_mv = xv; v.x_msop = xs;
    v.x_meop = xe; v.x_merr = xr; v.x_memp = xm; v.x_mdata = xd; v.x_rdy = xrdy; v.x_drop = xdrop;
    return v;
  endfunction

  // driver
  task automatic drive(input logic r, rdy, input logic [3:0] v, s, e,
                       input logic er, input logic [2:0] em, input logic [15:0] t);
    reset = r; m_ready = rdy;
    src_valid = v; src_startofpacket = s; src_endofpacket = e;
    src_error = {4{er}}; src_empty = {4{em}};
    for (int i = 0; i < 4; i++) src_data[64*i +: 64] = dat(i, t);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step %0d: got %h expected %h", name, cur, act, exp);
    end
  endtask

  task automatic chk_vec(input vec_t v);
    chk("grant", 64'(grant), 64'(v.x_grant));
    chk("busy", 64'(busy), 64'(v.x_busy));
    chk("m_valid", 64'(m_valid), 64'(v.x_mv));
    chk("m_sop", 64'(m_startofpacket), 64'(v.x_msop));
    chk("m_eop", 64'(m_endofpacket), 64'(v.x_meop));
    chk("m_error", 64'(m_error), 64'(v.x_merr));
    chk("m_empty", 64'(m_empty), 64'(v.x_memp));
    chk("m_data", m_data, v.x_mdata);
    chk("src_ready", 64'(src_ready), 64'(v.x_rdy));
    chk("drop_pulse", 64'(drop_pulse), 64'(v.x_drop));
    chk("timeout_pulse", 64'(timeout_pulse), 64'(0));
  endtask

  task automatic step(input logic r, rdy, input logic [3:0] v, s, e, input logic [15:0] t);
    @(posedge clk); #1;
    drive(r, rdy, v, s, e, 1'b0, 3'd0, t);
    @(negedge clk);
    cur++;
  endtask

  initial begin
    drive(1'b1, 1'b1, 4'b0, 4'b0, 4'b0, 1'b0, 3'd0, 16'h0);
    repeat (2) @(posedge clk);

    // port 2 three-beat packet
    vecs.push_back(mk(1,1,4'b0100,4'b0100,4'b0000,0,0,16'h1111, 4'b0000,0,0,0,0,0,0,64'h0,4'b0000,0));
    vecs.push_back(mk(0,1,4'b0100,4'b0100,4'b0000,0,0,16'h1111, 4'b0000,0,0,0,0,0,0,64'h0,4'b0000,0));
    vecs.push_back(mk(0,1,4'b0100,4'b0100,4'b0000,0,0,16'h1111, 4'b0100,1,1,1,0,0,0,dat(2,16'h1111),4'b0100,0));
    vecs.push_back(mk(0,1,4'b0100,4'b0000,4'b0000,0,0,16'h2222, 4'b0100,1,1,0,0,0,0,dat(2,16'h2222),4'b0100,0));
    vecs.push_back(mk(0,1,4'b0100,4'b0000,4'b0100,0,2,16'h3333, 4'b0100,1,1,0,1,0,2,dat(2,16'h3333),4'b0100,0));
    vecs.push_back(mk(0,1,4'b0000,4'b0000,4'b0000,0,0,16'h0,    4'b0000,0,0,0,0,0,0,64'h0,4'b0000,0));
    // stray beat on port 3 while idle
    vecs.push_back(mk(0,1,4'b1000,4'b0000,4'b0000,0,0,16'h0,    4'b0000,0,0,0,0,0,0,64'h0,4'b1000,1));
    vecs.push_back(mk(0,1,4'b0000,4'b0000,4'b0000,0,0,16'h0,    4'b0000,0,0,0,0,0,0,64'h0,4'b0000,0));
    // reset then round robin over ports 0,1,3 with single-beat packets
    vecs.push_back(mk(1,1,4'b0000,4'b0000,4'b0000,0,0,16'h0,    4'b0000,0,0,0,0,0,0,64'h0,4'b0000,0));
    for (int n = 0; n < 6; n++) begin
      int p;
      p = (n % 3 == 2) ? 3 : n % 3;
      vecs.push_back(mk(0,1,4'b1011,4'b1011,4'b1011,0,0,16'hAAAA, 4'b0000,0,0,0,0,0,0,64'h0,4'b0000,0));
      vecs.push_back(mk(0,1,4'b1011,4'b1011,4'b1011,0,0,16'hAAAA, 4'(1 << p),1,1,1,1,0,0,dat(p,16'hAAAA),4'(1 << p),0));
    end
    // port 1 packet with 5 stalled cycles while port 0 waits with SOP
    vecs.push_back(mk(0,1,4'b0010,4'b0010,4'b0000,0,0,16'h0001, 4'b0000,0,0,0,0,0,0,64'h0,4'b0000,0));
    vecs.push_back(mk(0,1,4'b0010,4'b0010,4'b0000,0,0,16'h0001, 4'b0010,1,1,1,0,0,0,dat(1,16'h0001),4'b0010,0));
    vecs.push_back(mk(0,1,4'b0011,4'b0001,4'b0000,1,0,16'h0002, 4'b0010,1,1,0,0,1,0,dat(1,16'h0002),4'b0010,0));
    for (int n = 0; n < 5; n++)
      vecs.push_back(mk(0,0,4'b0011,4'b0001,4'b0010,0,0,16'h0003, 4'b0010,1,1,0,1,0,0,dat(1,16'h0003),4'b0000,0));
    vecs.push_back(mk(0,1,4'b0011,4'b0001,4'b0010,0,0,16'h0003, 4'b0010,1,1,0,1,0,0,dat(1,16'h0003),4'b0010,0));
    vecs.push_back(mk(0,1,4'b0001,4'b0001,4'b0001,0,0,16'h0004, 4'b0000,0,0,0,0,0,0,64'h0,4'b0000,0));
    vecs.push_back(mk(0,1,4'b0001,4'b0001,4'b0001,0,0,16'h0004, 4'b0001,1,1,1,1,0,0,dat(0,16'h0004),4'b0001,0));
    // reset on second beat of a port 0 packet
    vecs.push_back(mk(0,1,4'b0001,4'b0001,4'b0000,0,0,16'h0010, 4'b0000,0,0,0,0,0,0,64'h0,4'b0000,0));
    vecs.push_back(mk(0,1,4'b0001,4'b0001,4'b0000,0,0,16'h0010, 4'b0001,1,1,1,0,0,0,dat(0,16'h0010),4'b0001,0));
    vecs.push_back(mk(1,1,4'b0001,4'b0000,4'b0000,0,0,16'h0011, 4'b0000,0,0,0,0,0,0,64'h0,4'b0000,0));
    vecs.push_back(mk(0,1,4'b0011,4'b0010,4'b0000,0,0,16'h0012, 4'b0000,0,0,0,0,0,0,64'h0,4'b0001,1));
    vecs.push_back(mk(0,1,4'b0011,4'b0010,4'b0010,0,0,16'h0013, 4'b0010,1,1,1,1,0,0,dat(1,16'h0013),4'b0010,0));
    vecs.push_back(mk(0,1,4'b0000,4'b0000,4'b0000,0,0,16'h0,    4'b0000,0,0,0,0,0,0,64'h0,4'b0000,0));

    foreach (vecs[i]) begin
      @(posedge clk); #1;
      drive(vecs[i].rst, vecs[i].rdy, vecs[i].vld, vecs[i].sop, vecs[i].eop,
            vecs[i].err, vecs[i].emp, vecs[i].tag);
      @(negedge clk);
      cur = i;
      chk_vec(vecs[i]);
    end

    // port 2 opens a packet then goes quiet
    cur = 1000;
    step(0, 1, 4'b0100, 4'b0100, 4'b0000, 16'h5555);
    chk("hold_idle_grant", 64'(grant), 64'(0));
    step(0, 1, 4'b0100, 4'b0100, 4'b0000, 16'h5555);
    chk("hold_grant", 64'(grant), 64'(4'b0100));
    chk("hold_sop_data", m_data, dat(2, 16'h5555));
`ifdef ARB_TIMEOUT_EN
    for (int k = 1; k <= 8; k++) begin
      step(0, 1, 4'b0000, 4'b0000, 4'b0000, 16'h0);
      chk("to_pulse", 64'(timeout_pulse), 64'(k == 8));
      chk("to_busy", 64'(busy), 64'(1));
      chk("to_mvalid", 64'(m_valid), 64'(0));
    end
    for (int k = 0; k < 2; k++) begin
      step(0, 1'(k), 4'b0000, 4'b0000, 4'b0000, 16'h0);
      chk("abort_mvalid", 64'(m_valid), 64'(1));
      chk("abort_sop", 64'(m_startofpacket), 64'(0));
      chk("abort_eop", 64'(m_endofpacket), 64'(1));
      chk("abort_err", 64'(m_error), 64'(1));
      chk("abort_empty", 64'(m_empty), 64'(7));
      chk("abort_data", m_data, 64'h0);
      chk("abort_pulse", 64'(timeout_pulse), 64'(0));
      chk("abort_grant", 64'(grant), 64'(4'b0100));
    end
    step(0, 1, 4'b0100, 4'b0000, 4'b0100, 16'h5556);
    chk("late_ready", 64'(src_ready), 64'(4'b0100));
    chk("late_drop", 64'(drop_pulse), 64'(1));
    chk("late_mvalid", 64'(m_valid), 64'(0));
    chk("late_grant", 64'(grant), 64'(0));
    step(0, 1, 4'b0000, 4'b0000, 4'b0000, 16'h0);
    chk("late_drop_end", 64'(drop_pulse), 64'(0));
`else
    for (int k = 0; k < 20; k++) begin
      step(0, 1, 4'b0000, 4'b0000, 4'b0000, 16'h0);
      chk("hold_busy", 64'(busy), 64'(1));
      chk("hold_grant_q", 64'(grant), 64'(4'b0100));
      chk("hold_mvalid", 64'(m_valid), 64'(0));
      chk("hold_pulse", 64'(timeout_pulse), 64'(0));
    end
    step(0, 1, 4'b0100, 4'b0000, 4'b0100, 16'h5556);
    chk("hold_eop", 64'(m_endofpacket), 64'(1));
    chk("hold_eop_data", m_data, dat(2, 16'h5556));
    chk("hold_eop_ready", 64'(src_ready), 64'(4'b0100));
    step(0, 1, 4'b0000, 4'b0000, 4'b0000, 16'h0);
    chk("hold_release", 64'(busy), 64'(0));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
